sram_dp_pipe: RTL and testbench

Parametrised, generalised dual-port synchronous SRAM. It succeeds the basic sram_dp and adds:
- per-lane write enables
- a configurable read pipeline with valid strobes
- a defined same-address collision policy
- a hardware clear sequencer that initialises every word to a constant

Used as working-matrix and seed storage inside the FrodoKEM datapath. Both ports are fully independent read/write ports on one clock.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_rd_pipe.sv | 58 +++++
 rtl/sram_dp_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_sram_dp_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the pipelined dual-port SRAM.
//   - clear-sequencer state encoding
//   - lane-count helper (WIDTH / LANE_WIDTH)
//   - legal read-latency bounds and their check
package sram_pkg;

    typedef logic [1:0] clr_state_t;

    localparam clr_state_t CLR_IDLE  = 2'd0;
    localparam clr_state_t CLR_CLEAR = 2'd1;
    localparam clr_state_t CLR_DONE  = 2'd2;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 3;

    function automatic int lane_count(input int width, input int lane_width);
        return width / lane_width;
    endfunction

    function automatic bit rd_latency_ok(input int latency);
        return (latency >= RD_LATENCY_MIN) && (latency <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: data + valid delay line for one read port.
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low flush (clears valid and data)
//   i_valid  valid strobe entering the line
//   i_data   data entering the line
//   o_valid  valid strobe after STAGES cycles
//   o_data   data after STAGES cycles; holds the last valid word
// STAGES = 0 degenerates to a wire.
module sram_rd_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = i_clk ^ i_rst_n;
            assign o_valid = i_valid;
            assign o_data  = i_data;
        end else begin : g_pipe
            logic [STAGES-1:0] valid_q;
            logic [WIDTH-1:0]  data_q [STAGES];

            // Data registers only load alongside a valid strobe, so the
            // final stage naturally holds the last completed read.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    valid_q <= '0;
                    for (int s = 0; s < STAGES; s++) begin
                        data_q[s] <= '0;
                    end
                end else begin
                    valid_q[0] <= i_valid;
                    if (i_valid) begin
                        data_q[0] <= i_data;
                    end
                    for (int s = 1; s < STAGES; s++) begin
                        valid_q[s] <= valid_q[s-1];
                        if (valid_q[s-1]) begin
                            data_q[s] <= data_q[s-1];
                        end
                    end
                end
            end

            assign o_valid = valid_q[STAGES-1];
            assign o_data  = data_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sram_dp_pipe.sv
// sram_dp_pipe: dual-port synchronous SRAM with lane write enables,
// configurable read latency, defined collision policy and a hardware
// clear sequencer.
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_ce_n                  chip enable (active-low), gates both ports
//   i_clr, o_busy           start clear / clear in progress
//   o_clr_done              one-cycle pulse after the last clear write
//   i_rdwr_n_<p>            port p access type (0 = write, 1 = read)
//   i_we_lane_<p>           port p lane write enables
//   i_addr_<p>, i_data_<p>  port p address / write data
//   o_data_<p>, o_valid_<p> port p read data / read valid
//
// Clear FSM:
//   state     | meaning
//   CLR_IDLE  | normal port operation, waiting for i_clr
//   CLR_CLEAR | writing CLR_VALUE to two words per cycle, ports blocked
//   CLR_DONE  | one-cycle o_clr_done pulse, ports usable again
module sram_dp_pipe
    import sram_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               ADDR_WIDTH = 4,
    parameter int               LANE_WIDTH = 8,
    parameter int               RD_LATENCY = 1,
    parameter int               READ_FIRST = 1,
    parameter logic [WIDTH-1:0] CLR_VALUE  = '0,
    localparam int              LANES      = lane_count(WIDTH, LANE_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ce_n,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_clr_done,
    input  logic                  i_rdwr_n_0,
    input  logic [LANES-1:0]      i_we_lane_0,
    input  logic [ADDR_WIDTH-1:0] i_addr_0,
    input  logic [WIDTH-1:0]      i_data_0,
    output logic [WIDTH-1:0]      o_data_0,
    output logic                  o_valid_0,
    input  logic                  i_rdwr_n_1,
    input  logic [LANES-1:0]      i_we_lane_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    input  logic [WIDTH-1:0]      i_data_1,
    output logic [WIDTH-1:0]      o_data_1,
    output logic                  o_valid_1
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 2);
    localparam logic [ADDR_WIDTH-1:0] CNT_STEP = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] CNT_ODD  = ADDR_WIDTH'(1);

    generate
        if (!rd_latency_ok(RD_LATENCY) || (WIDTH % LANE_WIDTH) != 0 || ADDR_WIDTH < 1) begin : g_param_check
            $error("sram_dp_pipe: illegal parameter combination");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    clr_state_t            state_q;
    clr_state_t            state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy;

    // ---------------- clear FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= CLR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_IDLE:  if (i_clr) state_d = CLR_CLEAR;
            CLR_CLEAR: if (cnt_q == CNT_LAST) state_d = CLR_DONE;
            CLR_DONE:  state_d = CLR_IDLE;
            default:   state_d = CLR_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == CLR_CLEAR);
        o_clr_done = (state_q == CLR_DONE);
    end

    assign o_busy = busy;

    // Counter stops at the last pair instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (state_q == CLR_IDLE && i_clr) begin
            cnt_q <= '0;
        end else if (busy && cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_STEP;
        end
    end

    // ---------------- port qualification ----------------
    logic access;
    logic rd_0, wr_0, rd_1, wr_1;
    logic clr_wr;

    assign access = i_rst_n && !i_ce_n && !busy;
    assign rd_0   = access &&  i_rdwr_n_0;
    assign wr_0   = access && !i_rdwr_n_0;
    assign rd_1   = access &&  i_rdwr_n_1;
    assign wr_1   = access && !i_rdwr_n_1;
    assign clr_wr = i_rst_n && busy;

    // ---------------- memory array ----------------
    // Port 1 lanes are assigned first so port 0 overrides shared lanes on a
    // same-address write collision.
    always_ff @(posedge i_clk) begin
        if (clr_wr) begin
            mem[cnt_q]           <= CLR_VALUE;
            mem[cnt_q | CNT_ODD] <= CLR_VALUE;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_1 && i_we_lane_1[k]) begin
                    mem[i_addr_1][k*LANE_WIDTH +: LANE_WIDTH] <= i_data_1[k*LANE_WIDTH +: LANE_WIDTH];
                end
                if (wr_0 && i_we_lane_0[k]) begin
                    mem[i_addr_0][k*LANE_WIDTH +: LANE_WIDTH] <= i_data_0[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Overlay the other port's same-edge write onto a stored word.
    function automatic logic [WIDTH-1:0] merge_write(
        input logic [WIDTH-1:0]      base,
        input logic                  wr,
        input logic [LANES-1:0]      we,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [WIDTH-1:0]      wd,
        input logic [ADDR_WIDTH-1:0] ra
    );
        logic [WIDTH-1:0] w;
        w = base;
        if (wr && wa == ra) begin
            for (int k = 0; k < LANES; k++) begin
                if (we[k]) begin
                    w[k*LANE_WIDTH +: LANE_WIDTH] = wd[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        return w;
    endfunction

    logic [WIDTH-1:0] rd_word_0;
    logic [WIDTH-1:0] rd_word_1;

    always_comb begin
        rd_word_0 = mem[i_addr_0];
        rd_word_1 = mem[i_addr_1];
        if (READ_FIRST == 0) begin
            rd_word_0 = merge_write(mem[i_addr_0], wr_1, i_we_lane_1, i_addr_1, i_data_1, i_addr_0);
            rd_word_1 = merge_write(mem[i_addr_1], wr_0, i_we_lane_0, i_addr_0, i_data_0, i_addr_1);
        end
    end

    // ---------------- read stage + delay lines ----------------
    logic             rd_valid_q0, rd_valid_q1;
    logic [WIDTH-1:0] rd_data_q0,  rd_data_q1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_valid_q0 <= 1'b0;
            rd_valid_q1 <= 1'b0;
            rd_data_q0  <= '0;
            rd_data_q1  <= '0;
        end else begin
            rd_valid_q0 <= rd_0;
            rd_valid_q1 <= rd_1;
            if (rd_0) rd_data_q0 <= rd_word_0;
            if (rd_1) rd_data_q1 <= rd_word_1;
        end
    end

    sram_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe_0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (rd_valid_q0),
        .i_data  (rd_data_q0),
        .o_valid (o_valid_0),
        .o_data  (o_data_0)
    );

    sram_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe_1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (rd_valid_q1),
        .i_data  (rd_data_q1),
        .o_valid (o_valid_1),
        .o_data  (o_data_1)
    );

endmodule

// File: tb/tb_sram_dp_pipe.sv
// tb_sram_dp_pipe: directed bench for sram_dp_pipe. Two instances share all
// stimulus: u_dut_rf (READ_FIRST=1) and u_dut_wf (READ_FIRST=0). Reads push
// hand-computed expectations (with due cycle) into per-stream queues; a
// negedge monitor pops and compares whenever a DUT raises o_valid.
module tb_sram_dp_pipe;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n, ce_n, clr;
    logic        rdwr_n_0, rdwr_n_1;
    logic [1:0]  we_lane_0, we_lane_1;
    logic [3:0]  addr_0, addr_1;
    logic [15:0] data_0, data_1;

    logic        a_busy, a_done, a_valid_0, a_valid_1;
    logic [15:0] a_data_0, a_data_1;
    logic        b_busy, b_done, b_valid_0, b_valid_1;
    logic [15:0] b_data_0, b_data_1;

    always #5 clk = ~clk;

    sram_dp_pipe #(
        .WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RD_LATENCY(RD_LAT),
        .READ_FIRST(1), .CLR_VALUE(16'h0000)
    ) u_dut_rf (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_n(ce_n), .i_clr(clr),
        .o_busy(a_busy), .o_clr_done(a_done),
        .i_rdwr_n_0(rdwr_n_0), .i_we_lane_0(we_lane_0), .i_addr_0(addr_0),
        .i_data_0(data_0), .o_data_0(a_data_0), .o_valid_0(a_valid_0),
        .i_rdwr_n_1(rdwr_n_1), .i_we_lane_1(we_lane_1), .i_addr_1(addr_1),
        .i_data_1(data_1), .o_data_1(a_data_1), .o_valid_1(a_valid_1)
    );

    sram_dp_pipe #(
        .WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RD_LATENCY(RD_LAT),
        .READ_FIRST(0), .CLR_VALUE(16'h0000)
    ) u_dut_wf (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_n(ce_n), .i_clr(clr),
        .o_busy(b_busy), .o_clr_done(b_done),
        .i_rdwr_n_0(rdwr_n_0), .i_we_lane_0(we_lane_0), .i_addr_0(addr_0),
        .i_data_0(data_0), .o_data_0(b_data_0), .o_valid_0(b_valid_0),
        .i_rdwr_n_1(rdwr_n_1), .i_we_lane_1(we_lane_1), .i_addr_1(addr_1),
        .i_data_1(data_1), .o_data_1(b_data_1), .o_valid_1(b_valid_1)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    // streams: 0 = rf port0, 1 = rf port1, 2 = wf port0, 3 = wf port1
    exp_t q0[$], q1[$], q2[$], q3[$];

    logic        pend_0 = 1'b0, pend_1 = 1'b0;
    logic [15:0] pend_rf_0, pend_wf_0, pend_rf_1, pend_wf_1;

    task automatic push(input int s, input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + RD_LAT - 1;
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic qpop(input int s);
        case (s)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic mon(input int s, input logic v, input logic [15:0] d);
        exp_t e;
        int   n;
        case (s)
            0: n = q0.size();
            1: n = q1.size();
            2: n = q2.size();
            default: n = q3.size();
        endcase
        if (n > 0) begin
            case (s)
                0: e = q0[0];
                1: e = q1[0];
                2: e = q2[0];
                default: e = q3[0];
            endcase
        end
        if (v === 1'b1) begin
            checks++;
            if (n == 0) begin
                failures++;
                $display("FAIL rd_stream%0d unexpected valid: actual data=%h cycle=%0d, required no valid", s, d, cyc);
            end else begin
                qpop(s);
                if (d !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL rd_stream%0d: actual data=%h cycle=%0d, required data=%h cycle=%0d",
                             s, d, cyc, e.data, e.due);
                end
            end
        end else if (n > 0 && cyc > e.due) begin
            checks++;
            failures++;
            $display("FAIL rd_stream%0d missing valid: actual none by cycle %0d, required data=%h at cycle %0d",
                     s, cyc, e.data, e.due);
            qpop(s);
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_valid_0, a_data_0);
        mon(1, a_valid_1, a_data_1);
        mon(2, b_valid_0, b_data_0);
        mon(3, b_valid_1, b_data_1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle_ports();
        rdwr_n_0 = 1'b0; we_lane_0 = 2'b00; addr_0 = '0; data_0 = '0;
        rdwr_n_1 = 1'b0; we_lane_1 = 2'b00; addr_1 = '0; data_1 = '0;
        clr      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pend_0) begin push(0, pend_rf_0); push(2, pend_wf_0); end
        if (pend_1) begin push(1, pend_rf_1); push(3, pend_wf_1); end
        pend_0 = 1'b0;
        pend_1 = 1'b0;
        idle_ports();
    endtask

    task automatic p_wr(input int p, input logic [3:0] a, input logic [15:0] d, input logic [1:0] lanes);
        if (p == 0) begin rdwr_n_0 = 1'b0; addr_0 = a; data_0 = d; we_lane_0 = lanes; end
        else        begin rdwr_n_1 = 1'b0; addr_1 = a; data_1 = d; we_lane_1 = lanes; end
    endtask

    task automatic p_rd_drop(input int p, input logic [3:0] a);
        if (p == 0) begin rdwr_n_0 = 1'b1; addr_0 = a; we_lane_0 = 2'b00; end
        else        begin rdwr_n_1 = 1'b1; addr_1 = a; we_lane_1 = 2'b00; end
    endtask

    task automatic p_rd(input int p, input logic [3:0] a, input logic [15:0] rf, input logic [15:0] wf);
        p_rd_drop(p, a);
        if (p == 0) begin pend_0 = 1'b1; pend_rf_0 = rf; pend_wf_0 = wf; end
        else        begin pend_1 = 1'b1; pend_rf_1 = rf; pend_wf_1 = wf; end
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            p_wr(0, 4'(i),     base + 16'(i),     2'b11);
            p_wr(1, 4'(i + 8), base + 16'(i + 8), 2'b11);
            step();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy_rf"},   {31'd0, a_busy},    32'd0);
        chk({tag, "_busy_wf"},   {31'd0, b_busy},    32'd0);
        chk({tag, "_done_rf"},   {31'd0, a_done},    32'd0);
        chk({tag, "_valid0_rf"}, {31'd0, a_valid_0}, 32'd0);
        chk({tag, "_valid1_rf"}, {31'd0, a_valid_1}, 32'd0);
        chk({tag, "_valid0_wf"}, {31'd0, b_valid_0}, 32'd0);
        chk({tag, "_data0_rf"},  {16'd0, a_data_0},  32'd0);
        chk({tag, "_data1_rf"},  {16'd0, a_data_1},  32'd0);
        chk({tag, "_data0_wf"},  {16'd0, b_data_0},  32'd0);
    endtask

    initial begin
        int busy_a, busy_b, done_a, done_b, done_at, k;

        rst_n = 1'b0;
        ce_n  = 1'b0;
        idle_ports();
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // initial clear so every word is defined
        clr = 1'b1;
        step();
        k = 0;
        while (a_done !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("init_clr_done_rf", {31'd0, a_done}, 32'd1);
        chk("init_clr_done_wf", {31'd0, b_done}, 32'd1);
        step();

        // back-to-back reads of the cleared array
        for (int i = 0; i < 16; i++) begin
            p_rd(0, 4'(i), 16'h0000, 16'h0000);
            step();
        end
        step();
        chk("burst_last_valid", {31'd0, a_valid_0}, 32'd1);
        step();
        chk("burst_valid_after", {31'd0, a_valid_0}, 32'd0);

        // lane writes
        p_wr(0, 4'd3, 16'hABCD, 2'b11); step();
        p_wr(0, 4'd3, 16'h1234, 2'b01); step();
        p_rd(1, 4'd3, 16'hAB34, 16'hAB34); step();

        // write-write collisions
        p_wr(0, 4'd5, 16'h1111, 2'b11); p_wr(1, 4'd5, 16'h2222, 2'b11); step();
        p_wr(0, 4'd6, 16'h3333, 2'b01); p_wr(1, 4'd6, 16'h4444, 2'b11); step();
        p_rd(0, 4'd5, 16'h1111, 16'h1111); p_rd(1, 4'd6, 16'h4433, 16'h4433); step();
        // read-write collision: old word on rf, merged word on wf
        p_wr(0, 4'd5, 16'h5555, 2'b11); p_rd(1, 4'd5, 16'h1111, 16'h5555); step();
        p_rd(0, 4'd5, 16'h5555, 16'h5555); step();
        // partial-lane read-write collision on wf
        p_wr(1, 4'd5, 16'h9988, 2'b10); p_rd(0, 4'd5, 16'h5555, 16'h9955); step();
        step();

        // chip enable blocks both ports
        ce_n = 1'b1;
        p_wr(0, 4'd2, 16'hFFFF, 2'b11); p_rd_drop(1, 4'd2); step();
        ce_n = 1'b0;
        // empty lane mask writes nothing
        p_wr(0, 4'd2, 16'hEEEE, 2'b00); step();
        p_rd(1, 4'd2, 16'h0000, 16'h0000); step();
        repeat (2) step();

        // clear with pre-clear read, dropped accesses and a re-trigger while busy
        fill(16'h0000);
        p_rd(0, 4'd9, 16'h0009, 16'h0009);
        clr = 1'b1;
        step();
        busy_a = 0; busy_b = 0; done_a = 0; done_b = 0; done_at = -1;
        for (int it = 0; it < 14; it++) begin
            if (a_busy === 1'b1) busy_a++;
            if (b_busy === 1'b1) busy_b++;
            if (a_done === 1'b1) begin done_a++; done_at = it; end
            if (b_done === 1'b1) done_b++;
            if (it == 0) begin
                p_wr(0, 4'd7, 16'h7777, 2'b11);
                p_rd_drop(1, 4'd7);
            end
            if (it == 2) clr = 1'b1;
            step();
        end
        chk("clr_busy_cycles_rf", 32'(busy_a), 32'd8);
        chk("clr_busy_cycles_wf", 32'(busy_b), 32'd8);
        chk("clr_done_pulses_rf", 32'(done_a), 32'd1);
        chk("clr_done_pulses_wf", 32'(done_b), 32'd1);
        chk("clr_done_position",  32'(done_at), 32'd8);
        for (int i = 0; i < 16; i++) begin
            p_rd(0, 4'(i), 16'h0000, 16'h0000);
            step();
        end
        repeat (3) step();

        // reset in the third clear cycle
        fill(16'h0100);
        p_rd(0, 4'd9, 16'h0109, 16'h0109);
        step();
        repeat (2) step();
        clr = 1'b1;
        step();
        repeat (2) step();
        rst_n = 1'b0;
        step();
        chk_reset_outputs("midclr");
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            p_rd(0, 4'(i), 16'h0000, 16'h0000);
            step();
        end

        k = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) > 0 && k < 10) begin
            step();
            k++;
        end
        chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
